// File: rtl/vector_mem_sequencer.sv
// Vector memory sequencer for VLD/VST: computes the effective address once,
// then walks the lanes issuing one word access per lane over a req/ack port.
// Loads assemble returned words into rdata; stores slice the latched vector.
module vector_mem_sequencer #(
   parameter int LANES = 16,
   parameter int DW    = 16,
   parameter int AW    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                is_store,
   input  logic [AW-1:0]       base,
   input  logic [AW-1:0]       offset,
   input  logic [LANES*DW-1:0] wdata,
   output logic                busy,
   output logic                done,
   output logic [LANES*DW-1:0] rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_wdata,
   input  logic                mem_ack,
   input  logic [DW-1:0]       mem_rdata
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]          state_q,    state_d;
   logic [IW-1:0]       idx_q,      idx_d;
   logic [AW-1:0]       ea_q,       ea_d;
   logic                is_store_q, is_store_d;
   logic [LANES*DW-1:0] wdata_q,    wdata_d;
   logic [LANES*DW-1:0] rdata_q,    rdata_d;

   // Next-state logic: operand capture in IDLE, lane stepping on each ack.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      ea_d       = ea_q;
      is_store_d = is_store_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ea_d       = base + offset;
               is_store_d = is_store;
               wdata_d    = wdata;
               idx_d      = '0;
               state_d    = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (mem_ack) begin
               if (!is_store_q) begin
                  rdata_d[DW*idx_q +: DW] = mem_rdata;
               end
               if (idx_q == IW'(LANES - 1)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset also clears partial load data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         ea_q       <= '0;
         is_store_q <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         ea_q       <= ea_d;
         is_store_q <= is_store_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   // Request outputs decode from registered state only, so they hold steady
   // across wait states and read as zero outside ACCESS.
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == S_ACCESS) begin
         mem_req   = 1'b1;
         mem_we    = is_store_q;
         mem_addr  = ea_q + AW'(idx_q);
         mem_wdata = wdata_q[DW*idx_q +: DW];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed plus randomized bench for vector_mem_sequencer with a lane-level
// reference model of addresses, store data and assembled load vectors.
module tb_vector_mem_sequencer;

   localparam int LANES = 16;
   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int VW    = LANES * DW;

   logic          clk;
   logic          rst;
   logic          start;
   logic          is_store;
   logic [AW-1:0] base;
   logic [AW-1:0] offset;
   logic [VW-1:0] wdata;
   logic          busy;
   logic          done;
   logic [VW-1:0] rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   int            errors = 0;
   int            checks = 0;
   logic [VW-1:0] rdata_model;
   logic [DW-1:0] salt;

   vector_mem_sequencer #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_store  (is_store),
      .base      (base),
      .offset    (offset),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory contents: a fixed function of the address, perturbed by salt.
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return (a + 16'hA000) ^ salt;
   endfunction

   // One operation, sampled on falling edges. wmode < 0 gives random waits
   // per lane; restart_lane / rst_lane >= 0 inject a stray start or a reset.
   task automatic run_op(input logic st, input logic [AW-1:0] b, input logic [AW-1:0] o,
                         input logic [VW-1:0] wd, input int wmode,
                         input int restart_lane, input int rst_lane);
      logic [AW-1:0] ea;
      logic [AW-1:0] exp_addr;
      logic [VW-1:0] exp_rdata;
      int            lane;
      int            waited;
      int            need;
      int            cyc;
      logic          acked;
      bit            fin;
      ea        = b + o;
      exp_rdata = rdata_model;
      @(negedge clk);
      start = 1'b1; is_store = st; base = b; offset = o; wdata = wd; mem_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      is_store = ~st; base = 16'($urandom); offset = 16'($urandom);
      wdata = {8{$urandom}};
      cyc = 1; lane = 0; waited = 0; fin = 0;
      need = (wmode < 0) ? int'($urandom_range(0, 2)) : wmode;
      while (!fin) begin
         if (cyc > 400) begin
            checks++; errors++;
            $error("FAIL timeout got=no_done exp=done");
            break;
         end
         exp_addr = ea + AW'(lane);
         chk("busy", busy, 1);
         chk("mem_req", mem_req, 1);
         chk("done_early", done, 0);
         chk("mem_we", mem_we, st);
         chk("mem_addr", mem_addr, exp_addr);
         if (st) chk("mem_wdata", mem_wdata, wd[DW*lane +: DW]);
         mem_ack = 1'b0;
         if (lane == rst_lane) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            rdata_model = '0;
            chk("rst_mem_req", mem_req, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rdata", rdata, 0);
            return;
         end
         if (lane == restart_lane && waited == 0) begin
            start = 1'b1; base = 16'h5555; offset = 16'h0001; is_store = ~st;
         end else begin
            start = 1'b0;
         end
         acked = (waited >= need);
         mem_ack = acked;
         mem_rdata = acked ? mem_word(mem_addr) : 16'($urandom);
         if (acked && !st) exp_rdata[DW*lane +: DW] = mem_word(exp_addr);
         @(negedge clk);
         cyc++;
         if (acked) begin
            if (lane == LANES - 1) fin = 1;
            else begin
               lane++;
               waited = 0;
               need = (wmode < 0) ? int'($urandom_range(0, 2)) : wmode;
            end
         end else begin
            waited++;
         end
      end
      mem_ack = 1'b0; start = 1'b0;
      chk("done", done, 1);
      chk("done_mem_req", mem_req, 0);
      chk("done_busy", busy, 1);
      chk("rdata", rdata, exp_rdata);
      rdata_model = exp_rdata;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_done", done, 0);
         chk("post_busy", busy, 0);
         chk("post_mem_req", mem_req, 0);
         chk("post_rdata", rdata, rdata_model);
      end
   endtask

   initial begin
      logic [VW-1:0] wd;
      rst = 1'b1; start = 1'b0; is_store = 1'b0; base = '0; offset = '0;
      wdata = '0; mem_ack = 1'b0; mem_rdata = '0; salt = '0; rdata_model = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy0", busy, 0);
      chk("rst_done0", done, 0);
      chk("rst_req0", mem_req, 0);
      chk("rst_we0", mem_we, 0);
      chk("rst_addr0", mem_addr, 0);
      chk("rst_wdata0", mem_wdata, 0);
      chk("rst_rdata0", rdata, 0);
      rst = 1'b0;

      // Ack with no request pending must be ignored.
      mem_ack = 1'b1; mem_rdata = 16'hFFFF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("spur_busy", busy, 0);
         chk("spur_req", mem_req, 0);
         chk("spur_rdata", rdata, 0);
      end
      mem_ack = 1'b0;

      // Load, zero wait: 0x0100 + (-2).
      run_op(1'b0, 16'h0100, 16'hFFFE, '0, 0, -1, -1);

      // Store with two wait states per lane.
      for (int i = 0; i < LANES; i++) wd[DW*i +: DW] = 16'(16'h1110 * i);
      run_op(1'b1, 16'h0020, 16'h0003, wd, 2, -1, -1);

      // Address wrap-around.
      run_op(1'b0, 16'hFFF0, 16'h0008, '0, 0, -1, -1);

      // Stray start at lane 5 must be ignored.
      salt = 16'h3C3C;
      run_op(1'b0, 16'h1234, 16'h0010, '0, 1, 5, -1);

      // Spurious ack after a load leaves rdata alone.
      mem_ack = 1'b1; mem_rdata = 16'h0BAD;
      repeat (2) @(negedge clk);
      chk("spur2_rdata", rdata, rdata_model);
      mem_ack = 1'b0;

      // Reset mid-load, then a clean load.
      run_op(1'b0, 16'h4000, 16'h0000, '0, 0, -1, 7);
      run_op(1'b0, 16'h4000, 16'h0100, '0, 0, -1, -1);

      // Randomized operations with random wait states.
      for (int n = 0; n < 8; n++) begin
         salt = 16'($urandom);
         for (int i = 0; i < LANES; i++) wd[DW*i +: DW] = 16'($urandom);
         run_op(1'($urandom), 16'($urandom), 16'($urandom), wd, -1, -1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
